// File: rtl/hmmm_io_unit.sv
// Console I/O unit for the HMMM core: WRITE words go through an output FIFO to
// the console sink; READ words are fetched from the console source by a small FSM.
module hmmm_io_unit #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        io_req,
  input  logic                        io_write,
  input  logic [15:0]                 io_wdata,
  output logic                        io_stall,
  output logic                        io_rvalid,
  output logic [15:0]                 io_rdata,
  output logic                        out_valid,
  output logic [15:0]                 out_data,
  input  logic                        out_ready,
  input  logic                        in_valid,
  input  logic [15:0]                 in_data,
  output logic                        in_ready,
  output logic [$clog2(FIFO_DEPTH):0] out_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [15:0]   mem_q [FIFO_DEPTH];

  logic fifoEmpty;
  logic fifoSpace;
  logic pop;
  logic push;
  logic capture;

  // A slot is free either because the FIFO is not full or because the head
  // leaves in this same cycle, so a full FIFO can still accept a write.
  assign fifoEmpty = (level_q == '0);
  assign pop       = !fifoEmpty && out_ready;
  assign fifoSpace = (level_q != DEPTH_L) || pop;
  assign push      = io_req && io_write && (state_q == IDLE) && fifoSpace;
  assign capture   = (state_q == RD_WAIT) && in_ready && in_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (io_req && !io_write) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (!io_req) begin
          state_d = IDLE;
        end else if (capture) begin
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Input is only taken once the FIFO has drained, so prompts always reach the
  // console before the read that answers them; a dropped request never consumes.
  always_comb begin
    io_stall  = 1'b0;
    io_rvalid = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        io_stall = io_req && (!io_write || !fifoSpace);
      end
      RD_WAIT: begin
        io_stall = io_req;
        in_ready = io_req && fifoEmpty;
      end
      RD_RESP: begin
        io_rvalid = 1'b1;
      end
      default: begin
        io_stall = 1'b0;
      end
    endcase
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    rdata_d = rdata_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (capture) begin
      rdata_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      rdata_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wrPtr_q] <= io_wdata;
    end
  end

  assign out_valid = !fifoEmpty;
  assign out_data  = mem_q[rdPtr_q];
  assign out_level = level_q;
  assign io_rdata  = rdata_q;

endmodule

// File: tb/tb_hmmm_io_unit.sv
// Directed self-checking bench for hmmm_io_unit (FIFO_DEPTH = 4).
module tb_hmmm_io_unit;

  logic        clock;
  logic        reset;
  logic        ioReq;
  logic        ioWrite;
  logic [15:0] ioWdata;
  logic        ioStall;
  logic        ioRvalid;
  logic [15:0] ioRdata;
  logic        outValid;
  logic [15:0] outData;
  logic        outReady;
  logic        inValid;
  logic [15:0] inData;
  logic        inReady;
  logic [2:0]  outLevel;

  int assertCount;
  int failCount;

  hmmm_io_unit #(.FIFO_DEPTH(4)) dut (
    .clk       (clock),
    .reset     (reset),
    .io_req    (ioReq),
    .io_write  (ioWrite),
    .io_wdata  (ioWdata),
    .io_stall  (ioStall),
    .io_rvalid (ioRvalid),
    .io_rdata  (ioRdata),
    .out_valid (outValid),
    .out_data  (outData),
    .out_ready (outReady),
    .in_valid  (inValid),
    .in_data   (inData),
    .in_ready  (inReady),
    .out_level (outLevel)
  );

  // Free-running 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive all core/console inputs, then let combinational outputs settle
  task automatic applyStimulus(input logic req, input logic wr, input logic [15:0] wdata,
                               input logic oReady, input logic iValid, input logic [15:0] iData);
    ioReq    = req;
    ioWrite  = wr;
    ioWdata  = wdata;
    outReady = oReady;
    inValid  = iValid;
    inData   = iData;
    #2;
  endtask

  // Advance to just after the next rising edge
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    // Reset state
    checkOutput("rst_level",  32'(outLevel), 0);
    checkOutput("rst_oval",   32'(outValid), 0);
    checkOutput("rst_stall",  32'(ioStall),  0);
    checkOutput("rst_rvalid", 32'(ioRvalid), 0);
    checkOutput("rst_inrdy",  32'(inReady),  0);
    checkOutput("rst_rdata",  32'(ioRdata),  0);
    checkOutput("rst_odata",  32'(outData),  0);
    cycle();
    cycle();
    reset = 1'b0;

    // Four writes fill the FIFO without stalling
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b1, 16'(i), 1'b0, 1'b0, 16'h0);
      checkOutput($sformatf("fill_stall_%0d", i), 32'(ioStall), 0);
      cycle();
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("full_level", 32'(outLevel), 4);
    checkOutput("full_oval",  32'(outValid), 1);

    // Fifth write stalls while the sink is blocked
    applyStimulus(1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0);
    checkOutput("w5_stall_a", 32'(ioStall), 1);
    cycle();
    checkOutput("w5_stall_b", 32'(ioStall),  1);
    checkOutput("w5_level_b", 32'(outLevel), 4);
    applyStimulus(1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h0);
    checkOutput("w5_accept",  32'(ioStall), 0);
    checkOutput("w5_head",    32'(outData), 32'h0001);
    cycle();
    checkOutput("w5_level_c", 32'(outLevel), 4);
    for (int i = 2; i <= 5; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
      checkOutput($sformatf("drain1_oval_%0d", i), 32'(outValid), 1);
      checkOutput($sformatf("drain1_data_%0d", i), 32'(outData), 32'(i));
      cycle();
    end
    checkOutput("drain1_empty", 32'(outValid), 0);
    checkOutput("drain1_level", 32'(outLevel), 0);

    // Full FIFO: write and pop in the same cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 16'(16'h0010 + i), 1'b0, 1'b0, 16'h0);
      cycle();
    end
    applyStimulus(1'b1, 1'b1, 16'h00AA, 1'b1, 1'b0, 16'h0);
    checkOutput("fullpp_stall", 32'(ioStall), 0);
    cycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    checkOutput("fullpp_level", 32'(outLevel), 4);
    checkOutput("fullpp_head",  32'(outData),  32'h0011);
    begin
      logic [15:0] expSeq [4];
      expSeq[0] = 16'h0011;
      expSeq[1] = 16'h0012;
      expSeq[2] = 16'h0013;
      expSeq[3] = 16'h00AA;
      for (int i = 0; i < 4; i++) begin
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        checkOutput($sformatf("drain2_data_%0d", i), 32'(outData), 32'(expSeq[i]));
        cycle();
      end
    end
    checkOutput("drain2_level", 32'(outLevel), 0);

    // Minimum-latency read: rvalid two cycles after request
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h1234);
    checkOutput("rd_n_stall",  32'(ioStall), 1);
    checkOutput("rd_n_inrdy",  32'(inReady), 0);
    cycle();
    checkOutput("rd_n1_inrdy", 32'(inReady),  1);
    checkOutput("rd_n1_stall", 32'(ioStall),  1);
    checkOutput("rd_n1_rval",  32'(ioRvalid), 0);
    cycle();
    checkOutput("rd_n2_rval",  32'(ioRvalid), 1);
    checkOutput("rd_n2_rdata", 32'(ioRdata),  32'h1234);
    checkOutput("rd_n2_stall", 32'(ioStall),  0);
    checkOutput("rd_n2_inrdy", 32'(inReady),  0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h9999);
    cycle();
    checkOutput("rd_after_rval",  32'(ioRvalid), 0);
    checkOutput("rd_after_rdata", 32'(ioRdata),  32'h1234);

    // Read waits for pending output to drain first
    applyStimulus(1'b1, 1'b1, 16'h0021, 1'b0, 1'b0, 16'h0);
    cycle();
    applyStimulus(1'b1, 1'b1, 16'h0022, 1'b0, 1'b0, 16'h0);
    cycle();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h5678);
    checkOutput("ord_req_stall", 32'(ioStall), 1);
    cycle();
    checkOutput("ord_w_inrdy_a", 32'(inReady), 0);
    cycle();
    checkOutput("ord_w_inrdy_b", 32'(inReady),  0);
    checkOutput("ord_w_rval_b",  32'(ioRvalid), 0);
    checkOutput("ord_w_level_b", 32'(outLevel), 2);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h5678);
    checkOutput("ord_pop_inrdy_a", 32'(inReady), 0);
    checkOutput("ord_pop_data_a",  32'(outData), 32'h0021);
    cycle();
    checkOutput("ord_pop_inrdy_b", 32'(inReady),  0);
    checkOutput("ord_pop_data_b",  32'(outData),  32'h0022);
    checkOutput("ord_pop_level_b", 32'(outLevel), 1);
    cycle();
    checkOutput("ord_empty_inrdy", 32'(inReady),  1);
    checkOutput("ord_empty_rdata", 32'(ioRdata),  32'h1234);
    cycle();
    checkOutput("ord_rval",  32'(ioRvalid), 1);
    checkOutput("ord_rdata", 32'(ioRdata),  32'h5678);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cycle();

    // Request dropped while waiting for input
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cycle();
    checkOutput("abort_wait_inrdy", 32'(inReady), 1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'hBEEF);
    checkOutput("abort_drop_stall", 32'(ioStall), 0);
    checkOutput("abort_drop_inrdy", 32'(inReady), 0);
    cycle();
    checkOutput("abort_idle_inrdy", 32'(inReady),  0);
    checkOutput("abort_idle_rval",  32'(ioRvalid), 0);
    checkOutput("abort_idle_rdata", 32'(ioRdata),  32'h5678);
    cycle();
    checkOutput("abort_late_rval",  32'(ioRvalid), 0);

    // Asynchronous reset mid-read with three words queued
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 16'(16'h0030 + i), 1'b0, 1'b0, 16'h0);
      cycle();
    end
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cycle();
    checkOutput("arst_pre_level", 32'(outLevel), 3);
    checkOutput("arst_pre_stall", 32'(ioStall),  1);
    ioReq = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("arst_level", 32'(outLevel), 0);
    checkOutput("arst_oval",  32'(outValid), 0);
    checkOutput("arst_stall", 32'(ioStall),  0);
    checkOutput("arst_odata", 32'(outData),  0);
    checkOutput("arst_rdata", 32'(ioRdata),  0);
    cycle();
    reset = 1'b0;

    // First write right after release is accepted
    applyStimulus(1'b1, 1'b1, 16'h0077, 1'b0, 1'b1, 16'h4444);
    checkOutput("post_rst_stall", 32'(ioStall),  0);
    checkOutput("post_rst_rval",  32'(ioRvalid), 0);
    cycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h4444);
    checkOutput("post_rst_level", 32'(outLevel), 1);
    checkOutput("post_rst_head",  32'(outData),  32'h0077);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("post_rst_norval_%0d", i), 32'(ioRvalid), 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/hmmm_io_unit.md
HMMM_IO_UNIT -- requirements
Module: hmmm_io_unit

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, depth of the WRITE output FIFO; legal values are powers of two, 2 to 16.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 io_req  in  1  core presents a READ or WRITE instruction; held high while io_stall=1.
REQ-005 io_write  in  1  1=WRITE (print rX), 0=READ (load rX); valid when io_req=1.
REQ-006 io_wdata  in  16  rX contents for WRITE.
REQ-007 io_stall  out  1  core SHALL hold PC and instruction while high.
REQ-008 io_rvalid  out  1  one-cycle strobe; core writes io_rdata into rX.
REQ-009 io_rdata  out  16  READ result.
REQ-010 out_valid  out  1  FIFO head available to console sink.
REQ-011 out_data  out  16  FIFO head word.
REQ-012 out_ready  in  1  sink accepts head when out_valid=1.
REQ-013 in_valid  in  1  console source has a word.
REQ-014 in_data  in  16  console input word.
REQ-015 in_ready  out  1  unit accepts in_data this cycle.
REQ-016 out_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 WRITE path: FIFO push when io_req=1, io_write=1, state=IDLE, and (level<FIFO_DEPTH or pop this cycle); the write is accepted in the same cycle with io_stall=0.
REQ-018 WRITE with FIFO full and no pop this cycle: io_stall=1, no push; retried every cycle until accepted.
REQ-019 Pop: out_valid=(level!=0); pop when out_valid and out_ready; out_data is the registered head, with no combinational path from io_wdata.
REQ-020 Simultaneous push and pop: level unchanged; at full, push is legal (pop frees slot same cycle).
REQ-021 Pointers wrap modulo FIFO_DEPTH; level never exceeds FIFO_DEPTH and never underflows.
REQ-022 FIFO preserves order; every accepted word appears on out_data exactly once.
REQ-023 READ FSM states: IDLE, RD_WAIT, RD_RESP.
REQ-024 IDLE with io_req=1, io_write=0: io_stall=1, next state RD_WAIT.
REQ-025 RD_WAIT: in_ready=(level==0), so READ never overtakes pending output (prompt-before-input ordering); io_stall=1.
REQ-026 RD_WAIT with in_valid and in_ready: capture in_data into io_rdata register; next state RD_RESP.
REQ-027 RD_RESP: io_rvalid=1, io_stall=0, io_rdata stable; next state IDLE unconditionally.
REQ-028 Minimum READ latency (FIFO empty, in_valid already high): request cycle N, capture at end of N+1, io_rvalid in N+2.
REQ-029 io_req dropped in RD_WAIT: abort to IDLE without capture; in_ready=0 from the next cycle.
REQ-030 in_ready=0 in IDLE and RD_RESP; input words are never consumed outside RD_WAIT.
REQ-031 No WRITE push is accepted in RD_WAIT or RD_RESP; FIFO pops continue during READ.
REQ-032 io_stall=0 whenever io_req=0.
REQ-033 io_rdata holds its last captured value until the next capture.

Reset
REQ-034 On reset assertion, asynchronously: state=IDLE, FIFO pointers=0, level=0, out_valid=0, io_rvalid=0, io_stall=0 (io_req=0 assumed by core), in_ready=0, io_rdata=0, out_data=0.
REQ-035 Reset during a READ or with a non-empty FIFO discards all in-flight data; no io_rvalid follows.
REQ-036 First push is legal on the first posedge after reset deasserts.

Verification
REQ-037 Four WRITEs 0x0001..0x0004 back-to-back with out_ready=0 -> io_stall=0 for all four, level=4; fifth WRITE 0x0005 -> io_stall=1 until out_ready=1, then 0x0001..0x0005 drain in order.
REQ-038 FIFO full with WRITE 0x00AA and out_ready=1 in the same cycle -> accepted, io_stall=0, level stays 4.
REQ-039 READ with empty FIFO, in_valid=1, in_data=0x1234 -> in_ready high 1 cycle, io_rvalid=1 with io_rdata=0x1234 exactly 2 cycles after request.
REQ-040 Two WRITEs pending, then READ with in_valid=1 -> in_ready stays 0 until level=0, then capture; input is never consumed early.
REQ-041 Reset asserted mid-RD_WAIT with level=3 -> immediately level=0, out_valid=0, io_stall=0; no io_rvalid after release.
REQ-042 io_req dropped in RD_WAIT -> IDLE next cycle, in_ready=0, io_rdata unchanged.
